// File: rtl/alu_issue_stage_if.sv
// Handshake and operand/result bus bundle between the issue stage, its
// upstream/downstream neighbours and the shared function-unit buses.
interface alu_issue_stage_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4,
  parameter int OPC_W   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OPC_W-1:0]     in_opcode;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     operand1;
  logic [WIDTH-1:0]     operand2;
  logic [NUM_OPS-1:0]   select;
  logic [WIDTH-1:0]     unit_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_zero;
  logic                 out_err;
  logic                 busy;

  // Issue stage side
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, unit_result, out_ready,
    output in_ready, operand1, operand2, select, out_valid, out_result,
           out_zero, out_err, busy
  );

  // Environment side: upstream source, function units, downstream sink
  modport master (
    output in_valid, in_opcode, in_a, in_b, unit_result, out_ready,
    input  in_ready, operand1, operand2, select, out_valid, out_result,
           out_zero, out_err, busy
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage in front of the 8-bit function units. Latches one
// operation, drives a one-hot unit select for SETTLE cycles, then captures
// the OR-combined unit result with zero/error flags for downstream.
module alu_issue_stage #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4,
  parameter int OPC_W   = 2,
  parameter int SETTLE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_stage_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg;
  logic [WIDTH-1:0]     operand1_reg;
  logic [WIDTH-1:0]     operand2_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [NUM_OPS-1:0]   select_reg;
  logic [NUM_OPS-1:0]   sel_dec;
  logic                 op_err_reg;
  logic                 zero_reg;
  logic                 err_reg;
  logic                 accept;
  logic                 capture;

  // Opcode k enables unit k; opcodes with no unit decode to an all-zero select
  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_dec
      assign sel_dec[gi] = (bus.in_opcode == OPC_W'(gi));
    end
  endgenerate

  // Next-state logic and the accept/capture strobes for the datapath
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Operand latch, settle counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      operand1_reg <= '0;
      operand2_reg <= '0;
      select_reg   <= '0;
      cnt_reg      <= 4'd0;
      op_err_reg   <= 1'b0;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else if (accept) begin
      operand1_reg <= bus.in_a;
      operand2_reg <= bus.in_b;
      select_reg   <= sel_dec;
      op_err_reg   <= ~|sel_dec;
      cnt_reg      <= CNT_INIT;
    end else if (capture) begin
      result_reg   <= bus.unit_result;
      zero_reg     <= (bus.unit_result == '0);
      err_reg      <= op_err_reg;
      select_reg   <= '0;
    end else if (state_reg == DRIVE) begin
      cnt_reg      <= cnt_reg - 4'd1;
    end
  end

  // Operands persist after DRIVE; only select gates the units
  assign bus.operand1   = operand1_reg;
  assign bus.operand2   = operand2_reg;
  assign bus.select     = select_reg;
  assign bus.out_result = result_reg;
  assign bus.out_zero   = zero_reg;
  assign bus.out_err    = err_reg;
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: two instances (SETTLE=1/NUM_OPS=4 and
// SETTLE=3/NUM_OPS=3) surrounded by behavioural function units, checked
// against an opcode-level reference of the expected result and timing.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int total = 0;
  int bad   = 0;

  alu_issue_stage_if #(.WIDTH(8), .NUM_OPS(4), .OPC_W(2)) bus_a ();
  alu_issue_stage_if #(.WIDTH(8), .NUM_OPS(3), .OPC_W(2)) bus_b ();

  alu_issue_stage #(.WIDTH(8), .NUM_OPS(4), .OPC_W(2), .SETTLE(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave));
  alu_issue_stage #(.WIDTH(8), .NUM_OPS(3), .OPC_W(2), .SETTLE(3)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave));

  // Function units: 0 AND, 1 OR, 2 XOR, 3 ADD; unselected units output 0
  function automatic logic [7:0] unit_f(input int k, input logic [7:0] a, input logic [7:0] b);
    case (k)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return a + b;
    endcase
  endfunction

  always_comb begin
    bus_a.unit_result = 8'h00;
    for (int k = 0; k < 4; k++)
      if (bus_a.select[k]) bus_a.unit_result |= unit_f(k, bus_a.operand1, bus_a.operand2);
  end

  always_comb begin
    bus_b.unit_result = 8'h00;
    for (int k = 0; k < 3; k++)
      if (bus_b.select[k]) bus_b.unit_result |= unit_f(k, bus_b.operand1, bus_b.operand2);
  end

  // Reference: expected {err, result} for an opcode on a stage with nops units
  function automatic logic [8:0] ref_op(input int opc, input logic [7:0] a, input logic [7:0] b,
                                        input int nops);
    int r;
    if (opc >= nops) return {1'b1, 8'h00};
    case (opc)
      0: r = int'(a & b);
      1: r = int'(a | b);
      2: r = int'(a ^ b);
      default: r = (int'(a) + int'(b)) % 256;
    endcase
    return {1'b0, 8'(r)};
  endfunction

  task automatic wait_ready_a(input string tag);
    int n = 0;
    while (bus_a.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL %s ready_timeout in_ready=%b expected 1", tag, bus_a.in_ready); end
  endtask

  task automatic wait_ready_b(input string tag);
    int n = 0;
    while (bus_b.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL %s ready_timeout in_ready=%b expected 1", tag, bus_b.in_ready); end
  endtask

  // One op on instance A (SETTLE=1). If pre is set, the next op is presented
  // while DONE is stalled and must not be accepted before in_ready returns.
  task automatic op_a(input string tag, input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                      input int hold, input bit pre, input logic [1:0] popc,
                      input logic [7:0] pa, input logic [7:0] pb);
    logic [8:0] exp;
    logic [3:0] es;
    logic [7:0] r0;
    exp = ref_op(int'(opc), a, b, 4);
    es  = 4'b0001 << opc;
    wait_ready_a(tag);
    bus_a.in_opcode = opc; bus_a.in_a = a; bus_a.in_b = b; bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_opcode = 2'($urandom); bus_a.in_a = 8'($urandom); bus_a.in_b = 8'($urandom);
    total++;
    if (bus_a.select !== es || bus_a.operand1 !== a || bus_a.operand2 !== b || bus_a.busy !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      bad++; $display("FAIL %s drive sel=%b op1=%h op2=%h busy=%b vld=%b expected sel=%b op1=%h op2=%h busy=1 vld=0",
                      tag, bus_a.select, bus_a.operand1, bus_a.operand2, bus_a.busy, bus_a.out_valid, es, a, b);
    end
    @(posedge clk); #1;
    total++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_result !== exp[7:0] || bus_a.out_zero !== (exp[7:0] == 8'h00) ||
        bus_a.out_err !== exp[8] || bus_a.select !== 4'b0000) begin
      bad++; $display("FAIL %s result vld=%b res=%h z=%b e=%b sel=%b expected vld=1 res=%h z=%b e=%b sel=0000",
                      tag, bus_a.out_valid, bus_a.out_result, bus_a.out_zero, bus_a.out_err, bus_a.select,
                      exp[7:0], exp[7:0] == 8'h00, exp[8]);
    end
    r0 = bus_a.out_result;
    if (pre) begin
      bus_a.in_opcode = popc; bus_a.in_a = pa; bus_a.in_b = pb; bus_a.in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_result !== r0 || bus_a.in_ready !== 1'b0 || bus_a.select !== 4'b0000) begin
        bad++; $display("FAIL %s stall%0d vld=%b res=%h rdy=%b sel=%b expected vld=1 res=%h rdy=0 sel=0000",
                        tag, i, bus_a.out_valid, bus_a.out_result, bus_a.in_ready, bus_a.select, r0);
      end
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.select !== 4'b0000) begin
      bad++; $display("FAIL %s handshake vld=%b rdy=%b sel=%b expected vld=0 rdy=1 sel=0000",
                      tag, bus_a.out_valid, bus_a.in_ready, bus_a.select);
    end
  endtask

  // One op on instance B (SETTLE=3, three units)
  task automatic op_b(input string tag, input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                      input int hold);
    logic [8:0] exp;
    logic [2:0] es;
    logic [7:0] r0;
    exp = ref_op(int'(opc), a, b, 3);
    es  = (opc < 2'd3) ? (3'b001 << opc) : 3'b000;
    wait_ready_b(tag);
    bus_b.in_opcode = opc; bus_b.in_a = a; bus_b.in_b = b; bus_b.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus_b.select !== es || bus_b.out_valid !== 1'b0 || bus_b.busy !== 1'b1) begin
        bad++; $display("FAIL %s drive%0d sel=%b vld=%b busy=%b expected sel=%b vld=0 busy=1",
                        tag, i, bus_b.select, bus_b.out_valid, bus_b.busy, es);
      end
      bus_b.in_opcode = 2'($urandom); bus_b.in_a = 8'($urandom); bus_b.in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    total++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_result !== exp[7:0] || bus_b.out_zero !== (exp[7:0] == 8'h00) ||
        bus_b.out_err !== exp[8] || bus_b.select !== 3'b000) begin
      bad++; $display("FAIL %s result vld=%b res=%h z=%b e=%b sel=%b expected vld=1 res=%h z=%b e=%b sel=000",
                      tag, bus_b.out_valid, bus_b.out_result, bus_b.out_zero, bus_b.out_err, bus_b.select,
                      exp[7:0], exp[7:0] == 8'h00, exp[8]);
    end
    r0 = bus_b.out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus_b.out_valid !== 1'b1 || bus_b.out_result !== r0) begin
        bad++; $display("FAIL %s stall%0d vld=%b res=%h expected vld=1 res=%h", tag, i, bus_b.out_valid, bus_b.out_result, r0);
      end
    end
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;
    total++;
    if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s handshake vld=%b rdy=%b expected vld=0 rdy=1", tag, bus_b.out_valid, bus_b.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.in_valid = 1'b1; bus_b.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_a.operand1, bus_a.operand2, bus_a.select, bus_a.out_result, bus_a.out_zero, bus_a.out_err, bus_a.out_valid} !== '0 ||
        {bus_b.operand1, bus_b.operand2, bus_b.select, bus_b.out_result, bus_b.out_zero, bus_b.out_err, bus_b.out_valid} !== '0) begin
      bad++; $display("FAIL reset_outputs a_sel=%b a_res=%h a_vld=%b b_sel=%b b_res=%h b_vld=%b expected all 0",
                      bus_a.select, bus_a.out_result, bus_a.out_valid, bus_b.select, bus_b.out_result, bus_b.out_valid);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1 || bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
      bad++; $display("FAIL reset_ready a_rdy=%b b_rdy=%b a_busy=%b b_busy=%b expected rdy=1 busy=0",
                      bus_a.in_ready, bus_b.in_ready, bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic test_directed();
    op_a("and_f0_3c", 2'd0, 8'hF0, 8'h3C, 0, 1'b0, 2'd0, 8'h00, 8'h00);
    op_a("and_zero",  2'd0, 8'hAA, 8'h55, 0, 1'b0, 2'd0, 8'h00, 8'h00);
    op_a("add_wrap",  2'd3, 8'hFF, 8'h01, 0, 1'b0, 2'd0, 8'h00, 8'h00);
  endtask

  task automatic test_backpressure();
    op_a("stall5", 2'd1, 8'h12, 8'h40, 5, 1'b1, 2'd2, 8'h0F, 8'hFF);
    op_a("queued", 2'd2, 8'h0F, 8'hFF, 0, 1'b0, 2'd0, 8'h00, 8'h00);
  endtask

  task automatic test_error_op();
    op_b("err_op3", 2'd3, 8'hC3, 8'h5A, 1);
    op_b("b_or",    2'd1, 8'h81, 8'h18, 0);
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    wait_ready_b("abort");
    bus_b.in_opcode = 2'd2; bus_b.in_a = 8'h77; bus_b.in_b = 8'h11; bus_b.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    total++;
    if (bus_b.select !== 3'b000 || bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_state sel=%b vld=%b rdy=%b expected sel=000 vld=0 rdy=1",
                      bus_b.select, bus_b.out_valid, bus_b.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus_b.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_valid cycles_valid=%0d expected 0", seen); end
    op_b("after_abort", 2'd0, 8'h3C, 8'hF0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      op_a("rand_a", 2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0, 2'd0, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++)
      op_b("rand_b", 2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_opcode = '0; bus_a.in_a = '0; bus_a.in_b = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_opcode = '0; bus_b.in_a = '0; bus_b.in_b = '0; bus_b.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_error_op();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
